fsk_char_deframer: RTL
======================

# fsk_char_deframer

Downstream of the mark and space Goertzel filters. Pairs their per-window power results, slices each window into one FSK symbol bit, and generates the window-start pulse that re-arms both filters. Deframes the symbol stream as asynchronous 5-bit ITA2/Baudot characters (start, data LSB first, stop). Outputs characters with a framing-error flag to the character decoder.

## Interface
Parameters:
- POWER_WIDTH, 56, width of each signed power input (2 × filter ACC_WIDTH).
- DATA_BITS, 5, data bits per character.
- STOP_BITS, 1, stop symbols checked per character (1 or 2).
- SQUELCH_THRESH, 0, carrier threshold on power; used only with FSK_SQUELCH_EN.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- mark_valid  in  1  one-cycle strobe, mark filter result ready.
- mark_power  in  POWER_WIDTH signed  mark-tone window power.
- space_valid  in  1  one-cycle strobe, space filter result ready.
- space_power  in  POWER_WIDTH signed  space-tone window power.
- win_start  out  1  one-cycle pulse to the start input of both filters.
- sym_valid  out  1  one-cycle strobe, symbol decided.
- sym_bit  out  1  decided symbol: 1 = mark, 0 = space.
- carrier_det  out  1  carrier present for the last symbol.
- char_valid  out  1  one-cycle strobe, character complete.
- char_data  out  DATA_BITS  received character, bit 0 first on air.
- frame_err  out  1  qualifies char_valid: stop symbol was not mark.

## Operation
- Pairing: each valid latches its power and sets a have flag. If a valid arrives while its have flag is already set, the latch is overwritten with the newest value. A pair is complete when both flags are set, or when one is set and the other valid arrives, or when both valids arrive in the same cycle.
- Decision on pair completion: sym_bit = (mark_power >= space_power). Signed compare; a tie decides mark. Both have flags clear in the same edge.
- Window control: an arm flag is set in reset. win_start pulses on the first cycle after rst_n release. It also pulses the cycle after every pair completion. Only one pulse is issued per completion.
- FSM states: IDLE, DATA, STOP.
  - IDLE: a mark symbol stays in IDLE. A space symbol is a start bit: clear the shift register and bit count, then go to DATA.
  - DATA: shift sym_bit in LSB first. After DATA_BITS symbols, go to STOP.
  - STOP: check STOP_BITS symbols. Any space symbol sets the error. After the last stop symbol, pulse char_valid with char_data and frame_err, then go to IDLE. The character is always emitted, including on framing error.
- The FSM advances only on pair completion.

## Timing
- Reset values: win_start 0, sym_valid 0, sym_bit 1, carrier_det 0, char_valid 0, char_data 0, frame_err 0, FSM IDLE, have flags 0.
- Decision latency: one edge. Let edge E be the edge where the pair completes. At E, sym_valid, sym_bit and win_start are registered and the FSM updates. char_valid and frame_err register at the same edge E as the final stop symbol's decision.
- Strobes are high exactly one cycle.
- Reset mid-character: the partial character is discarded, no char_valid, and the block re-arms through the post-reset win_start.

## Configuration
- FSK_SQUELCH_EN defined:
  - At decision, carrier = (mark_power >= SQUELCH_THRESH) or (space_power >= SQUELCH_THRESH); carrier_det takes this value.
  - No carrier: sym_valid still pulses with sym_bit = 1, the FSM is forced to IDLE, and any partial character is dropped without char_valid.
- FSK_SQUELCH_EN undefined: carrier_det is 1 after the first decision, SQUELCH_THRESH is ignored, and all symbols feed the FSM.

## Structure
- Shared package fsk_pkg holds:
  - the FSM state enum (IDLE, DATA, STOP);
  - the ITA2 data width constant (5);
  - the symbol encoding constants MARK = 1, SPACE = 0.
- Sub-module fsk_power_pair holds the pairing latches, have flags and pair-complete strobe. Its outputs are the latched mark and space powers.

## Test plan
- Release reset → win_start pulses on the first cycle after release only; all other outputs keep their reset values.
- Send symbols space, 1,0,1,0,0, mark (same-cycle valids, mark = 1000 / space = 10 for 1, reversed for 0) → char_valid with char_data = 5'b00101 and frame_err = 0; win_start pulses after each of the 7 pairs.
- Same frame but the stop symbol is space (mark = 10, space = 1000) → char_valid with frame_err = 1, FSM returns to IDLE.
- mark_valid three cycles before space_valid, and a second mark_valid = 50 before space_valid = 40 → one decision only, uses 50, sym_bit = 1. Equal powers 500 / 500 → sym_bit = 1.
- FSK_SQUELCH_EN with SQUELCH_THRESH = 100: after a start bit and two data bits, send powers 20 / 30 → carrier_det = 0, FSM IDLE, no char_valid. The next valid frame decodes normally.
- Assert rst_n low during DATA, then release → no char_valid, outputs at reset values, one win_start after release.

Source files
------------

// File: rtl/fsk_pkg.sv
// Shared definitions for the FSK character deframer: FSM states, ITA2 width
// and symbol encoding.
package fsk_pkg;

   localparam int   ITA2_BITS = 5;
   localparam logic MARK      = 1'b1;
   localparam logic SPACE     = 1'b0;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      STOP
   } fsm_state_t;

endpackage

// File: rtl/fsk_power_pair.sv
// Pairs mark/space filter power results. Presents the newest power of each
// tone and a combinational pair-complete strobe for the deciding edge.
module fsk_power_pair
   import fsk_pkg::*;
#(
   parameter int POWER_WIDTH = 56
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          mark_valid,
   input  logic signed [POWER_WIDTH-1:0] mark_power,
   input  logic                          space_valid,
   input  logic signed [POWER_WIDTH-1:0] space_power,
   output logic                          pair_done,
   output logic signed [POWER_WIDTH-1:0] mark_sel,
   output logic signed [POWER_WIDTH-1:0] space_sel
);

   logic signed [POWER_WIDTH-1:0] mark_lat;
   logic signed [POWER_WIDTH-1:0] space_lat;
   logic                          have_mark;
   logic                          have_space;

   // A valid arriving on the completing cycle bypasses the latch so the
   // decision always sees the newest value.
   assign mark_sel  = mark_valid  ? mark_power  : mark_lat;
   assign space_sel = space_valid ? space_power : space_lat;
   assign pair_done = (have_mark | mark_valid) & (have_space | space_valid);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mark_lat   <= '0;
         space_lat  <= '0;
         have_mark  <= 1'b0;
         have_space <= 1'b0;
      end else begin
         if (mark_valid)
            mark_lat <= mark_power;
         if (space_valid)
            space_lat <= space_power;
         if (pair_done) begin
            have_mark  <= 1'b0;
            have_space <= 1'b0;
         end else begin
            if (mark_valid)
               have_mark <= 1'b1;
            if (space_valid)
               have_space <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/fsk_char_deframer.sv
// Slices paired Goertzel powers into FSK symbols and deframes async ITA2
// characters. Optional carrier squelch is enabled by defining FSK_SQUELCH_EN.
module fsk_char_deframer
   import fsk_pkg::*;
#(
   parameter int POWER_WIDTH    = 56,
   parameter int DATA_BITS      = ITA2_BITS,
   parameter int STOP_BITS      = 1,
   parameter int SQUELCH_THRESH = 0
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          mark_valid,
   input  logic signed [POWER_WIDTH-1:0] mark_power,
   input  logic                          space_valid,
   input  logic signed [POWER_WIDTH-1:0] space_power,
   output logic                          win_start,
   output logic                          sym_valid,
   output logic                          sym_bit,
   output logic                          carrier_det,
   output logic                          char_valid,
   output logic [DATA_BITS-1:0]          char_data,
   output logic                          frame_err
);

   localparam int CNT_W = $clog2(DATA_BITS + STOP_BITS + 1);

   logic                          pair_done;
   logic signed [POWER_WIDTH-1:0] mark_sel;
   logic signed [POWER_WIDTH-1:0] space_sel;
   logic                          carrier;
   logic                          dec_bit;

   logic                          arm;
   fsm_state_t                    state;
   logic [DATA_BITS-1:0]          shift;
   logic [CNT_W-1:0]              cnt;
   logic                          err_acc;

   fsk_power_pair #(
      .POWER_WIDTH (POWER_WIDTH)
   ) u_pair (
      .clk         (clk),
      .rst_n       (rst_n),
      .mark_valid  (mark_valid),
      .mark_power  (mark_power),
      .space_valid (space_valid),
      .space_power (space_power),
      .pair_done   (pair_done),
      .mark_sel    (mark_sel),
      .space_sel   (space_sel)
   );

`ifdef FSK_SQUELCH_EN
   localparam logic signed [POWER_WIDTH-1:0] THRESH = POWER_WIDTH'(SQUELCH_THRESH);
   assign carrier = (mark_sel >= THRESH) || (space_sel >= THRESH);
`else
   logic unused_thresh;
   assign unused_thresh = (SQUELCH_THRESH != 0);
   assign carrier       = 1'b1;
`endif

   // Ties decide mark; a squelched window always reads as idle mark.
   assign dec_bit = carrier ? (mark_sel >= space_sel) : MARK;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         arm         <= 1'b1;
         win_start   <= 1'b0;
         sym_valid   <= 1'b0;
         sym_bit     <= MARK;
         carrier_det <= 1'b0;
         char_valid  <= 1'b0;
         char_data   <= '0;
         frame_err   <= 1'b0;
         state       <= IDLE;
         shift       <= '0;
         cnt         <= '0;
         err_acc     <= 1'b0;
      end else begin
         arm        <= 1'b0;
         win_start  <= arm | pair_done;
         sym_valid  <= pair_done;
         char_valid <= 1'b0;
         if (pair_done) begin
            sym_bit     <= dec_bit;
            carrier_det <= carrier;
            if (!carrier) begin
               state <= IDLE;
            end else begin
               case (state)
                  IDLE: begin
                     if (dec_bit == SPACE) begin
                        shift <= '0;
                        cnt   <= '0;
                        state <= DATA;
                     end
                  end
                  DATA: begin
                     // LSB first: earliest data symbol ends up in bit 0.
                     shift <= (shift >> 1) | (DATA_BITS'(dec_bit) << (DATA_BITS - 1));
                     if (cnt == CNT_W'(DATA_BITS - 1)) begin
                        cnt     <= '0;
                        err_acc <= 1'b0;
                        state   <= STOP;
                     end else begin
                        cnt <= cnt + CNT_W'(1);
                     end
                  end
                  STOP: begin
                     if (cnt == CNT_W'(STOP_BITS - 1)) begin
                        char_valid <= 1'b1;
                        char_data  <= shift;
                        frame_err  <= err_acc | (dec_bit == SPACE);
                        state      <= IDLE;
                     end else begin
                        cnt <= cnt + CNT_W'(1);
                        if (dec_bit == SPACE)
                           err_acc <= 1'b1;
                     end
                  end
                  default: state <= IDLE;
               endcase
            end
         end
      end
   end

endmodule
